// File: rtl/display_scan_ctrl_if.sv
// Front-panel display bundle: the two pattern sources, the cook-status
// signals and the multiplexed seven-segment pin drive.
interface display_scan_ctrl_if;
    logic [1:0] mode;
    logic [6:0] word_seg3;
    logic [6:0] word_seg2;
    logic [6:0] word_seg1;
    logic [6:0] word_seg0;
    logic [6:0] time_seg3;
    logic [6:0] time_seg2;
    logic [6:0] time_seg1;
    logic [6:0] time_seg0;
    logic       done;
    logic       clear_done;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       src_word;

    // Panel controller side: supplies patterns and status, observes the pins.
    modport master (
        output mode,
        output word_seg3, word_seg2, word_seg1, word_seg0,
        output time_seg3, time_seg2, time_seg1, time_seg0,
        output done, clear_done,
        input  seg, an, dp, src_word
    );

    // Scan controller side.
    modport slave (
        input  mode,
        input  word_seg3, word_seg2, word_seg1, word_seg0,
        input  time_seg3, time_seg2, time_seg1, time_seg0,
        input  done, clear_done,
        output seg, an, dp, src_word
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Microwave front-panel 4-digit seven-segment scan controller.
// Chooses between the countdown digits and the cooking-mode word, shows the
// word for a hold time after a mode change, and blinks the time display once
// cooking has finished until the completion is acknowledged.
module display_scan_ctrl #(
    parameter int SCAN_DIV        = 100000,
    parameter int WORD_HOLD_TICKS = 2000,
    parameter int BLINK_TICKS     = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    display_scan_ctrl_if.slave    disp
);

    localparam int PRE_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HOLD_W  = $clog2(WORD_HOLD_TICKS + 1);
    localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(SCAN_DIV - 1);
    localparam logic [HOLD_W-1:0]  HOLD_INIT  = HOLD_W'(WORD_HOLD_TICKS);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

    typedef enum logic [1:0] {
        SHOW_TIME  = 2'd0,
        SHOW_WORD  = 2'd1,
        DONE_BLINK = 2'd2
    } state_t;

    logic [PRE_W-1:0]   prescaler;
    logic               tick;
    logic [1:0]         idx;
    logic [1:0]         mode_q;
    logic               done_q;
    logic               mode_chg;
    logic               done_rise;

    state_t             state;
    state_t             state_nx;
    logic [HOLD_W-1:0]  hold;
    logic [HOLD_W-1:0]  hold_nx;
    logic [BLINK_W-1:0] blink_cnt;
    logic [BLINK_W-1:0] blink_cnt_nx;
    logic               blank;
    logic               blank_nx;

    logic [6:0]         digit;
    logic [6:0]         seg_r;
    logic [3:0]         an_r;
    logic               dp_r;

    assign tick = (prescaler == PRE_LAST);

    // Scan-rate prescaler: free-running, one tick per digit slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end

    // Digit slot index: advances every tick in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= 2'd0;
        end else if (tick) begin
            idx <= idx + 2'd1;
        end
    end

    // Edge detectors for the mode selector and the done level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 2'b00;
            done_q <= 1'b0;
        end else begin
            mode_q <= disp.mode;
            done_q <= disp.done;
        end
    end

    // Mode 00 means "no mode" and never brings up a word.
    assign mode_chg  = (disp.mode != mode_q) && (disp.mode != 2'b00);
    assign done_rise = disp.done && !done_q;

    // Display-source state, word hold counter and blink phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SHOW_TIME;
            hold      <= '0;
            blink_cnt <= '0;
            blank     <= 1'b0;
        end else begin
            state     <= state_nx;
            hold      <= hold_nx;
            blink_cnt <= blink_cnt_nx;
            blank     <= blank_nx;
        end
    end

    // Next-state logic. Completion outranks everything; while blinking only
    // an acknowledge without a fresh completion edge returns to the time.
    always_comb begin
        state_nx     = state;
        hold_nx      = hold;
        blink_cnt_nx = blink_cnt;
        blank_nx     = blank;
        case (state)
            SHOW_TIME: begin
                if (done_rise) begin
                    // Blinking starts with the dark half-period.
                    state_nx     = DONE_BLINK;
                    blank_nx     = 1'b1;
                    blink_cnt_nx = '0;
                end else if (mode_chg) begin
                    state_nx = SHOW_WORD;
                    hold_nx  = HOLD_INIT;
                end
            end
            SHOW_WORD: begin
                if (done_rise) begin
                    state_nx     = DONE_BLINK;
                    blank_nx     = 1'b1;
                    blink_cnt_nx = '0;
                end else if (mode_chg) begin
                    hold_nx = HOLD_INIT;
                end else if (tick) begin
                    hold_nx = hold - HOLD_W'(1);
                    if (hold == HOLD_W'(1)) begin
                        state_nx = SHOW_TIME;
                    end
                end
            end
            DONE_BLINK: begin
                if (disp.clear_done && !done_rise) begin
                    state_nx     = SHOW_TIME;
                    blank_nx     = 1'b0;
                    blink_cnt_nx = '0;
                end else if (tick) begin
                    if (blink_cnt == BLINK_LAST) begin
                        blink_cnt_nx = '0;
                        blank_nx     = ~blank;
                    end else begin
                        blink_cnt_nx = blink_cnt + BLINK_W'(1);
                    end
                end
            end
            default: begin
                state_nx     = SHOW_TIME;
                blank_nx     = 1'b0;
                blink_cnt_nx = '0;
            end
        endcase
    end

    // Source arbitration: the word only while SHOW_WORD, otherwise the time.
    always_comb begin
        digit = 7'h7F;
        if (state == SHOW_WORD) begin
            case (idx)
                2'd0:    digit = disp.word_seg0;
                2'd1:    digit = disp.word_seg1;
                2'd2:    digit = disp.word_seg2;
                default: digit = disp.word_seg3;
            endcase
        end else begin
            case (idx)
                2'd0:    digit = disp.time_seg0;
                2'd1:    digit = disp.time_seg1;
                2'd2:    digit = disp.time_seg2;
                default: digit = disp.time_seg3;
            endcase
        end
    end

    // Registered pin drive, one cycle behind the slot index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r <= 7'h7F;
            an_r  <= 4'hF;
            dp_r  <= 1'b1;
        end else begin
            if (blank) begin
                seg_r <= 7'h7F;
                an_r  <= 4'hF;
            end else begin
                seg_r <= digit;
                an_r  <= ~(4'b0001 << idx);
            end
            // Colon-style separator between minutes and seconds.
            dp_r <= !((state == SHOW_TIME) && (idx == 2'd2));
        end
    end

    assign disp.seg      = seg_r;
    assign disp.an       = an_r;
    assign disp.dp       = dp_r;
    assign disp.src_word = (state == SHOW_WORD);

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a small scan divider.
module tb_display_scan_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   n;

    logic [3:0] an_tab [4];
    logic [6:0] tseg_tab [4];

    display_scan_ctrl_if dif ();

    display_scan_ctrl #(
        .SCAN_DIV       (4),
        .WORD_HOLD_TICKS(8),
        .BLINK_TICKS    (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .disp (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        n = n + 1;
    endtask

    task automatic step_to(input int target);
        while (n < target) step();
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        dif.mode       = 2'b00;
        dif.done       = 1'b0;
        dif.clear_done = 1'b0;
        dif.time_seg3  = 7'h40;
        dif.time_seg2  = 7'h79;
        dif.time_seg1  = 7'h24;
        dif.time_seg0  = 7'h30;
        dif.word_seg3  = 7'h47;
        dif.word_seg2  = 7'h23;
        dif.word_seg1  = 7'h7F;
        dif.word_seg0  = 7'h7F;
        #2;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++;
        if (dif.seg !== 7'h7F) begin
            failures++;
            $display("FAIL reset_seg got=%h want=7f", dif.seg);
        end
        checks++;
        if (dif.an !== 4'hF) begin
            failures++;
            $display("FAIL reset_an got=%h want=f", dif.an);
        end
        checks++;
        if (dif.dp !== 1'b1 || dif.src_word !== 1'b0) begin
            failures++;
            $display("FAIL reset_dp_src got=%b%b want=10", dif.dp, dif.src_word);
        end
        rst_n = 1'b1;
        n = 0;
    endtask

    task automatic test_scan_wrap();
        for (int i = 1; i <= 16; i++) begin
            int slot;
            step();
            slot = (i - 1) / 4;
            checks++;
            if (dif.an !== an_tab[slot] || dif.seg !== tseg_tab[slot]) begin
                failures++;
                $display("FAIL scan_edge%0d got an=%h seg=%h want an=%h seg=%h",
                         i, dif.an, dif.seg, an_tab[slot], tseg_tab[slot]);
            end
            checks++;
            if (dif.dp !== (slot == 2 ? 1'b0 : 1'b1) || dif.src_word !== 1'b0) begin
                failures++;
                $display("FAIL scan_dp_edge%0d got dp=%b src=%b want dp=%b src=0",
                         i, dif.dp, dif.src_word, (slot == 2 ? 1'b0 : 1'b1));
            end
        end
    endtask

    task automatic test_word_hold();
        dif.mode = 2'b01;
        step_to(17);
        checks++;
        if (dif.src_word !== 1'b1) begin
            failures++;
            $display("FAIL word_enter got=%b want=1", dif.src_word);
        end
        step_to(29);
        checks++;
        if (dif.an !== 4'h7 || dif.seg !== 7'h47) begin
            failures++;
            $display("FAIL word_digit3 got an=%h seg=%h want an=7 seg=47", dif.an, dif.seg);
        end
        step_to(47);
        checks++;
        if (dif.src_word !== 1'b1) begin
            failures++;
            $display("FAIL word_still_held got=%b want=1", dif.src_word);
        end
        step_to(48);
        checks++;
        if (dif.src_word !== 1'b0) begin
            failures++;
            $display("FAIL word_expire got=%b want=0", dif.src_word);
        end
    endtask

    task automatic test_hold_restart();
        dif.mode = 2'b00;
        step_to(49);
        dif.mode = 2'b01;
        step_to(50);
        checks++;
        if (dif.src_word !== 1'b1) begin
            failures++;
            $display("FAIL restart_enter got=%b want=1", dif.src_word);
        end
        step_to(68);
        dif.mode = 2'b11;
        step_to(80);
        checks++;
        if (dif.src_word !== 1'b1) begin
            failures++;
            $display("FAIL restart_extended got=%b want=1", dif.src_word);
        end
        step_to(99);
        checks++;
        if (dif.src_word !== 1'b1) begin
            failures++;
            $display("FAIL restart_last got=%b want=1", dif.src_word);
        end
        step_to(100);
        checks++;
        if (dif.src_word !== 1'b0) begin
            failures++;
            $display("FAIL restart_expire got=%b want=0", dif.src_word);
        end
    endtask

    task automatic test_done_blink();
        dif.done = 1'b1;
        step_to(102);
        checks++;
        if (dif.an !== 4'hF || dif.seg !== 7'h7F) begin
            failures++;
            $display("FAIL blink_dark1 got an=%h seg=%h want an=f seg=7f", dif.an, dif.seg);
        end
        step_to(108);
        checks++;
        if (dif.an !== 4'hF) begin
            failures++;
            $display("FAIL blink_dark_end got an=%h want=f", dif.an);
        end
        step_to(109);
        checks++;
        if (dif.an !== 4'h7 || dif.seg !== 7'h40 || dif.dp !== 1'b1) begin
            failures++;
            $display("FAIL blink_lit got an=%h seg=%h dp=%b want an=7 seg=40 dp=1",
                     dif.an, dif.seg, dif.dp);
        end
        step_to(110);
        dif.mode = 2'b01;
        step_to(111);
        checks++;
        if (dif.src_word !== 1'b0) begin
            failures++;
            $display("FAIL blink_mode_ignored got=%b want=0", dif.src_word);
        end
        step_to(112);
        checks++;
        if (dif.src_word !== 1'b0) begin
            failures++;
            $display("FAIL blink_mode_ignored2 got=%b want=0", dif.src_word);
        end
        step_to(117);
        checks++;
        if (dif.an !== 4'hF) begin
            failures++;
            $display("FAIL blink_dark2 got an=%h want=f", dif.an);
        end
    endtask

    task automatic test_clear_simul();
        step_to(118);
        dif.clear_done = 1'b1;
        step_to(119);
        dif.clear_done = 1'b0;
        step_to(120);
        checks++;
        if (dif.an !== 4'hD || dif.seg !== 7'h24 || dif.src_word !== 1'b0) begin
            failures++;
            $display("FAIL clear_unblank got an=%h seg=%h src=%b want an=d seg=24 src=0",
                     dif.an, dif.seg, dif.src_word);
        end
        dif.done = 1'b0;
        step_to(122);
        dif.done = 1'b1;
        step_to(123);
        dif.done = 1'b0;
        step_to(124);
        dif.done       = 1'b1;
        dif.clear_done = 1'b1;
        step_to(125);
        dif.clear_done = 1'b0;
        step_to(126);
        checks++;
        if (dif.an !== 4'hF || dif.seg !== 7'h7F) begin
            failures++;
            $display("FAIL simul_stay_blink got an=%h seg=%h want an=f seg=7f", dif.an, dif.seg);
        end
        step_to(127);
        checks++;
        if (dif.an !== 4'hF || dif.src_word !== 1'b0) begin
            failures++;
            $display("FAIL simul_stay_blink2 got an=%h src=%b want an=f src=0",
                     dif.an, dif.src_word);
        end
    endtask

    task automatic test_async_reset();
        dif.clear_done = 1'b1;
        step_to(128);
        dif.clear_done = 1'b0;
        dif.mode       = 2'b10;
        step_to(131);
        checks++;
        if (dif.src_word !== 1'b1 || dif.an === 4'hF) begin
            failures++;
            $display("FAIL pre_reset_word got src=%b an=%h want src=1 an!=f",
                     dif.src_word, dif.an);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dif.seg !== 7'h7F || dif.an !== 4'hF) begin
            failures++;
            $display("FAIL async_reset_pins got seg=%h an=%h want seg=7f an=f", dif.seg, dif.an);
        end
        checks++;
        if (dif.dp !== 1'b1 || dif.src_word !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_dp_src got dp=%b src=%b want dp=1 src=0",
                     dif.dp, dif.src_word);
        end
    endtask

    task automatic test_reset_with_mode();
        dif.done = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        step();
        checks++;
        if (dif.src_word !== 1'b1) begin
            failures++;
            $display("FAIL reset_mode_word got=%b want=1", dif.src_word);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        n        = 0;
        an_tab[0] = 4'hE;
        an_tab[1] = 4'hD;
        an_tab[2] = 4'hB;
        an_tab[3] = 4'h7;
        tseg_tab[0] = 7'h30;
        tseg_tab[1] = 7'h24;
        tseg_tab[2] = 7'h79;
        tseg_tab[3] = 7'h40;
        test_reset();
        test_scan_wrap();
        test_word_hold();
        test_hold_restart();
        test_done_blink();
        test_clear_simul();
        test_async_reset();
        test_reset_with_mode();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
